// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds or subtracts two WIDTH-bit operands one nibble per
// clock through an external 4-bit carry-lookahead adder. A ripple carry is
// held between steps. Subtraction is done as a + ~b + 1.
//
// Request/response protocol: start is a request pulse. It is taken only when
// the block is idle, and it is taken on the edge where start is high, even
// when abort is high on that edge. busy is high while nibble steps are in
// progress. A start seen while busy or done is dropped and not queued.
// done is a single-cycle pulse, and result/cout/ovf are valid while done is
// high. result then holds until the next accepted start. abort cancels a
// running operation and produces no done pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_ci,
  input  logic [3:0]       add_s,
  input  logic             add_co
);

  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The state register stays visible by name so that checkers can bind to it.
  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;

  // Controller: accepts a request, steps one nibble per edge, and flags completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= op_a;
            // For subtraction, b is stored inverted and the +1 enters as the first carry.
            b_reg  <= sub ? ~op_b : op_b;
            carry  <= sub;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result[4*idx +: 4] <= add_s;
            carry              <= add_co;
            if (idx == LAST_IDX) begin
              // The top nibble's sum bit 3 is the result MSB, so overflow can be resolved on this edge.
              cout  <= add_co;
              ovf   <= (a_reg[MSB] == b_reg[MSB]) && (add_s[3] != a_reg[MSB]);
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Adder feed: the current nibble pair and carry while running, zero otherwise.
  always_comb begin
    add_a  = 4'd0;
    add_b  = 4'd0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = a_reg[4*idx +: 4];
      add_b  = b_reg[4*idx +: 4];
      add_ci = carry;
    end
  end

endmodule
